dmem_responder: RTL

- Data-memory target serving the core's data-port initiator.
- Accepts word-aligned accesses with byte write masks.
- Returns read data with a fixed one-cycle latency.
- Contains a word-addressed RAM plus a small MMIO window:
  - free-running 64-bit cycle counter with a coherent high-word snapshot,
  - scratch register,
  - TOHOST halt register used by simulation benches to end a run.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Data-port bus between the core's data initiator and the data-memory target.
// Read data is returned one cycle after the address; there is no request strobe.
interface dmem_responder_if;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wmask;
    logic        data_wen;
    logic [31:0] data_rdata;

    modport master (
        output data_addr,
        output data_wdata,
        output data_wmask,
        output data_wen,
        input  data_rdata
    );

    modport slave (
        input  data_addr,
        input  data_wdata,
        input  data_wmask,
        input  data_wen,
        output data_rdata
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory target: word RAM with byte enables plus an MMIO window (cycle counter, scratch, TOHOST).
// Read latency is one cycle, write-first on collision; always ready, no backpressure.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
    parameter string       INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus,
    output logic              halt,
    output logic [31:0]       halt_code,
    output logic              bus_err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

    localparam logic [5:0] OFF_CYCLE_LO = 6'h00;
    localparam logic [5:0] OFF_CYCLE_HI = 6'h01;
    localparam logic [5:0] OFF_TOHOST   = 6'h02;
    localparam logic [5:0] OFF_SCRATCH  = 6'h03;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [5:0]    word_off;
    logic          ram_hit, mmio_hit, err_hit, wr_any, ram_we;
    logic [31:0]   ram_rd, ram_view;

    logic [63:0] cnt_q, cnt_d;
    logic [31:0] hi_snap_q, hi_snap_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] halt_code_q, halt_code_d;
    logic [31:0] rdata_q, rdata_d;
    logic        halt_q, halt_d;
    logic        bus_err_q, bus_err_d;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  lanes);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    always_comb begin
        idx      = bus.data_addr[AW+1:2];
        word_off = bus.data_addr[7:2];
        ram_hit  = {1'b0, bus.data_addr} < RAM_BYTES;
        mmio_hit = !ram_hit && (bus.data_addr[31:8] == MMIO_BASE[31:8]);
        err_hit  = !ram_hit && !mmio_hit;
        wr_any   = bus.data_wen && (bus.data_wmask != 4'h0);
        ram_we   = !rst && wr_any && ram_hit;

        // Bypass the write lanes so a same-cycle read sees the merged word.
        ram_rd   = mem[idx];
        ram_view = ram_we ? merge_bytes(ram_rd, bus.data_wdata, bus.data_wmask) : ram_rd;

        cnt_d       = cnt_q + 64'd1;
        hi_snap_d   = hi_snap_q;
        scratch_d   = scratch_q;
        halt_d      = halt_q;
        halt_code_d = halt_code_q;
        bus_err_d   = bus_err_q | err_hit;

        if (mmio_hit && wr_any) begin
            if (word_off == OFF_SCRATCH)
                scratch_d = merge_bytes(scratch_q, bus.data_wdata, bus.data_wmask);
            if (word_off == OFF_TOHOST && !halt_q) begin
                halt_code_d = merge_bytes(32'h0, bus.data_wdata, bus.data_wmask);
                halt_d      = 1'b1;
            end
        end

        rdata_d = 32'h0;
        if (ram_hit) begin
            rdata_d = ram_view;
        end else if (mmio_hit) begin
            case (word_off)
                OFF_CYCLE_LO: begin
                    rdata_d   = cnt_q[31:0];
                    hi_snap_d = cnt_q[63:32];
                end
                OFF_CYCLE_HI: rdata_d = hi_snap_q;
                OFF_TOHOST:   rdata_d = halt_code_d;
                OFF_SCRATCH:  rdata_d = scratch_d;
                default:      rdata_d = 32'h0;
            endcase
        end

        if (rst) begin
            cnt_d       = 64'h0;
            hi_snap_d   = 32'h0;
            scratch_d   = 32'h0;
            halt_d      = 1'b0;
            halt_code_d = 32'h0;
            bus_err_d   = 1'b0;
            rdata_d     = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q       <= cnt_d;
        hi_snap_q   <= hi_snap_d;
        scratch_q   <= scratch_d;
        halt_q      <= halt_d;
        halt_code_q <= halt_code_d;
        bus_err_q   <= bus_err_d;
        rdata_q     <= rdata_d;
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_wmask[i]) mem[idx][8*i +: 8] <= bus.data_wdata[8*i +: 8];
            end
        end
    end

    assign bus.data_rdata = rdata_q;
    assign halt           = halt_q;
    assign halt_code      = halt_code_q;
    assign bus_err        = bus_err_q;

endmodule
